fetch_unit: RTL and testbench

Instruction fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues in-order, latency-tolerant requests to instruction memory.
- Buffers returned words in a small FIFO and presents {pc, instr, end} to decode over a valid/ready handshake.
- Takes branch redirects from EX/MEM, which flush the queue and discard stale in-flight responses.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: widths, special instruction encodings and
// the fetch FSM state type.
package cpu_pkg;

  localparam int          XLEN       = 64;
  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fstate_e;

  function automatic logic is_end_marker(input logic [31:0] word);
    return word == END_MARKER;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with flush; head word is read straight from
// the storage registers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign data_o  = mem_q[rptr_q];

  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_pop  ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited imem
// requests, queues returned words and handles branch redirects.
module fetch_unit #(
  parameter int               XLEN      = cpu_pkg::XLEN,
  parameter int               QDEPTH    = 4,
  parameter int               MAX_OUTST = 2,
  parameter logic [XLEN-1:0]  RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_end,
  output logic            halted
);

  import cpu_pkg::*;

  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int CW  = QCW + OW + 1;
  localparam int EW  = XLEN + 33;

  logic [XLEN-1:0] pc_q, pc_d;
  fstate_e         state_q, state_d;
  logic [OW-1:0]   outst_q, outst_d, drop_q, drop_d;

  logic [QCW-1:0]  q_count;
  logic            q_full, q_empty, q_push, q_pop;
  logic [EW-1:0]   q_din, q_dout;

  logic [XLEN-1:0] t_dout;
  logic [OW-1:0]   t_count;
  logic            t_full, t_empty;

  logic [CW-1:0]   credit_used;
  logic            acc, resp, resp_drop, word_end;

  // Live credits: queued words plus responses that will still be enqueued.
  assign credit_used    = CW'(q_count) + CW'(outst_q) - CW'(drop_q);
  assign imem_req_valid = reset && (state_q == FS_RUN) &&
                          (outst_q < OW'(MAX_OUTST)) && (credit_used < CW'(QDEPTH));
  assign imem_req_addr  = pc_q;

  assign acc       = imem_req_valid && imem_req_ready;
  assign resp      = imem_resp_valid;
  assign resp_drop = resp && (drop_q != '0);
  assign word_end  = is_end_marker(imem_resp_data);
  assign q_push    = resp && !redirect_valid && (drop_q == '0);
  assign q_din     = {t_dout, imem_resp_data, word_end};

  assign out_valid = !q_empty;
  assign q_pop     = out_valid && out_ready;
  assign out_pc    = q_dout[EW-1:33];
  assign out_instr = q_dout[32:1];
  assign out_end   = q_dout[0];
  assign halted    = (state_q == FS_HALT);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    outst_d = outst_q + OW'(acc) - OW'(resp);
    drop_d  = drop_q - OW'(resp_drop);
    if (acc) pc_d = pc_q + XLEN'(4);
    if (q_push && word_end) state_d = FS_HALT;
    // Everything still in flight after this edge belongs to the old path.
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~XLEN'(3);
      state_d = FS_RUN;
      drop_d  = outst_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      state_q <= FS_RUN;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_prefetch_q (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redirect_valid),
    .push_i  (q_push),
    .data_i  (q_din),
    .pop_i   (q_pop),
    .data_o  (q_dout),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // Request PCs in issue order; every response pops one, stale or not.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tag_q (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (1'b0),
    .push_i  (acc),
    .data_i  (pc_q),
    .pop_i   (resp),
    .data_o  (t_dout),
    .full_o  (t_full),
    .empty_o (t_empty),
    .count_o (t_count)
  );

  a_resp_outst: assert property (@(posedge clk) disable iff (!reset)
                  imem_resp_valid |-> (outst_q != '0 && !t_empty));
  a_tag_room:   assert property (@(posedge clk) disable iff (!reset) !(acc && t_full));
  a_q_room:     assert property (@(posedge clk) disable iff (!reset) !(q_push && q_full && !q_pop));
  a_tag_sync:   assert property (@(posedge clk) disable iff (!reset) t_count == outst_q);
  a_drop_le:    assert property (@(posedge clk) disable iff (!reset) drop_q <= outst_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a request-level model
// of PC, in-flight requests (with stale flags) and the decode-side queue.
module tb_fetch_unit;

  localparam int          XLEN      = 64;
  localparam int          QDEPTH    = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] ENDW      = 32'hFFFF_FFFF;

  logic            clk, reset;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_end, halted;

  fetch_unit #(.XLEN(XLEN), .QDEPTH(QDEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_end         (out_end),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        e;
  } ent_t;

  ent_t        outq[$];
  logic [63:0] inf_pc[$];
  bit          inf_stale[$];
  int          inf_due[$];
  logic [63:0] mpc;
  bit          mhalt;
  int          cyc, checks, errors, nacc, first_ov, end_mode;
  logic [63:0] end_addr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if ((end_mode == 1 && a == end_addr) || (end_mode == 2 && a[6:2] == 5'd29)) return ENDW;
    return (a[31:0] * 32'h9E37_79B1 ^ 32'h5A5A_0F0F) & 32'h7FFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpc   = RESET_PC;
    mhalt = 0;
    outq.delete();
    inf_pc.delete();
    inf_stale.delete();
    inf_due.delete();
  endtask

  task automatic release_reset();
    imem_req_ready  = 0;
    imem_resp_valid = 0;
    redirect_valid  = 0;
    out_ready       = 0;
    reset    = 1'b1;
    model_reset();
    cyc      = 1;
    first_ov = -1;
    nacc     = 0;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    @(posedge clk);
    @(negedge clk);
    release_reset();
  endtask

  task automatic step(input bit rdy, input bit ordy, input bit ren, input bit redir,
                      input logic [63:0] rpc, input int lat);
    bit   rv, exp_rv, acc, enq, stale;
    int   live;
    ent_t e;
    live = 0;
    foreach (inf_stale[i]) if (!inf_stale[i]) live++;
    exp_rv = !mhalt && (inf_pc.size() < MAX_OUTST) && (outq.size() + live < QDEPTH);
    rv     = ren && (inf_pc.size() > 0) && (inf_due[0] <= cyc);
    imem_req_ready  = rdy;
    out_ready       = ordy;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_resp_valid = rv;
    imem_resp_data  = rv ? mem_word(inf_pc[0]) : $urandom;
    #1;
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, mpc);
    chk("out_valid", 64'(out_valid), 64'(outq.size() != 0));
    chk("halted", 64'(halted), 64'(mhalt));
    if (outq.size() != 0) begin
      chk("out_pc", out_pc, outq[0].pc);
      chk("out_instr", 64'(out_instr), 64'(outq[0].instr));
      chk("out_end", 64'(out_end), 64'(outq[0].e));
    end
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (imem_req_valid && imem_req_ready) nacc++;

    acc = exp_rv && rdy;
    enq = 0;
    e   = '{pc: 64'h0, instr: 32'h0, e: 1'b0};
    if (outq.size() != 0 && ordy) void'(outq.pop_front());
    if (rv) begin
      e.pc    = inf_pc.pop_front();
      e.instr = imem_resp_data;
      e.e     = (imem_resp_data == ENDW);
      stale   = inf_stale.pop_front();
      void'(inf_due.pop_front());
      enq = !redir && !stale;
      if (enq) outq.push_back(e);
    end
    if (redir) begin
      outq.delete();
      foreach (inf_stale[i]) inf_stale[i] = 1;
      if (acc) begin
        inf_pc.push_back(mpc); inf_stale.push_back(1); inf_due.push_back(cyc + lat);
      end
      mpc   = {rpc[63:2], 2'b00};
      mhalt = 0;
    end else begin
      if (acc) begin
        inf_pc.push_back(mpc); inf_stale.push_back(0); inf_due.push_back(cyc + lat);
        mpc = mpc + 64'd4;
      end
      if (enq && e.e) mhalt = 1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    checks = 0; errors = 0; end_mode = 0; end_addr = 64'h1;
    reset = 1'b0; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset_req_valid", 64'(imem_req_valid), 64'(0));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_halted", 64'(halted), 64'(0));
    release_reset();

    // Streaming, 1-cycle memory
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 64'h0, 1);
    chk("first_out_valid_cycle", 64'(first_ov), 64'(3));

    // Backpressure: credits cap accepts at QDEPTH, then drain in order
    mid_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 64'h0, 1);
    chk("bp_accepts", 64'(nacc), 64'(4));
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 64'h0, 1);

    // Redirect while 0x8 and 0xC are in flight
    mid_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 64'h0, 1);
    step(1, 1, 0, 0, 64'h0, 1);
    step(1, 1, 0, 1, 64'h40, 1);
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 64'h0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 64'h0, 1);

    // Redirect, accept and response in the same cycle
    mid_reset();
    step(1, 1, 1, 0, 64'h0, 1);
    step(1, 1, 1, 1, 64'h40, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 64'h0, 1);

    // End marker at 0x10, then resume via redirect to 0x80
    mid_reset();
    end_mode = 1; end_addr = 64'h10;
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 64'h0, 1);
    step(1, 1, 1, 1, 64'h80, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 64'h0, 1);
    end_mode = 0;

    // Reset with work queued and in flight
    mid_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 64'h0, 2);
    mid_reset();
    #1 chk("first_addr_after_reset", imem_req_addr, RESET_PC);
    step(1, 1, 1, 0, 64'h0, 1);

    // Random traffic
    end_mode = 2;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, {48'h0, 16'($urandom)}, $urandom_range(1, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
